// File: rtl/seg_595_rx.sv
// Receiver for a 74HC595-style serial display link: synchronizes the pins,
// rebuilds the 14-bit frame on each storage clock and keeps a per-digit segment memory.
module seg_595_rx #(
   parameter int FRAME_BITS  = 14,
   parameter int SYNC_STAGES = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        shcp,
   input  logic        stcp,
   input  logic        ds,
   input  logic        oe,
   output logic [5:0]  sel,
   output logic [7:0]  seg,
   output logic        blank,
   output logic        frame_valid,
   output logic        frame_err,
   output logic [47:0] digits
);

   localparam int CNT_W = $clog2(FRAME_BITS + 2);

   logic [SYNC_STAGES-1:0] shcp_sync, stcp_sync, ds_sync, oe_sync;
   logic                   shcp_edge, stcp_edge;
   logic                   shcp_rise, stcp_rise;
   logic                   shcp_rise_q, stcp_rise_q, ds_q;
   logic [FRAME_BITS-1:0]  shift_reg;
   logic [CNT_W-1:0]       bit_cnt;
   logic [13:0]            latch_frame;
   logic                   frame_bad;
   logic [47:0]            digits_next;

   assign shcp_rise = shcp_sync[SYNC_STAGES-1] & ~shcp_edge;
   assign stcp_rise = stcp_sync[SYNC_STAGES-1] & ~stcp_edge;
   assign blank     = oe_sync[SYNC_STAGES-1];

   // Input synchronizers, edge registers and a one-cycle detection stage.
   // The oe chain resets high so the display stays blanked until real oe arrives.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         shcp_sync   <= '0;
         stcp_sync   <= '0;
         ds_sync     <= '0;
         oe_sync     <= '1;
         shcp_edge   <= 1'b0;
         stcp_edge   <= 1'b0;
         shcp_rise_q <= 1'b0;
         stcp_rise_q <= 1'b0;
         ds_q        <= 1'b0;
      end else begin
         shcp_sync   <= {shcp_sync[SYNC_STAGES-2:0], shcp};
         stcp_sync   <= {stcp_sync[SYNC_STAGES-2:0], stcp};
         ds_sync     <= {ds_sync[SYNC_STAGES-2:0], ds};
         oe_sync     <= {oe_sync[SYNC_STAGES-2:0], oe};
         shcp_edge   <= shcp_sync[SYNC_STAGES-1];
         stcp_edge   <= stcp_sync[SYNC_STAGES-1];
         shcp_rise_q <= shcp_rise;
         stcp_rise_q <= stcp_rise;
         ds_q        <= ds_sync[SYNC_STAGES-1];
      end
   end

   always_comb begin
      latch_frame = shift_reg[13:0];
      frame_bad   = (bit_cnt != CNT_W'(FRAME_BITS)) ||
                    (latch_frame[5:0] == 6'd0) ||
                    ((latch_frame[5:0] & (latch_frame[5:0] - 6'd1)) != 6'd0);
      digits_next = digits;
      for (int unsigned i = 0; i < 6; i++) begin
         if (latch_frame[i])
            digits_next[8*i +: 8] = latch_frame[13:6];
      end
   end

   // Latch uses the pre-shift register, so a simultaneous shcp rise lands in the next frame.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         shift_reg   <= '0;
         bit_cnt     <= '0;
         sel         <= '0;
         seg         <= '0;
         digits      <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         if (shcp_rise_q)
            shift_reg <= {shift_reg[FRAME_BITS-2:0], ds_q};
         if (stcp_rise_q) begin
            {seg, sel}  <= latch_frame;
            frame_valid <= 1'b1;
            frame_err   <= frame_bad;
            if (!frame_bad)
               digits <= digits_next;
            bit_cnt <= shcp_rise_q ? CNT_W'(1) : '0;
         end else if (shcp_rise_q && bit_cnt != CNT_W'(FRAME_BITS + 1)) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_seg_595_rx.sv
// Bench for seg_595_rx: directed and random frames checked against a
// frame-level model (bit list, shift count, digit array).
module tb_seg_595_rx;

   logic        sys_clk = 1'b0;
   logic        sys_rst, shcp, stcp, ds, oe;
   logic [5:0]  sel;
   logic [7:0]  seg;
   logic        blank, frame_valid, frame_err;
   logic [47:0] digits;

   int total = 0;
   int bad   = 0;

   logic [13:0] m_shift;
   int          m_cnt;
   logic [5:0]  m_sel;
   logic [7:0]  m_seg;
   logic [7:0]  m_dig [6];
   logic        m_oe;

   seg_595_rx #(.FRAME_BITS(14), .SYNC_STAGES(2)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .shcp(shcp), .stcp(stcp),
      .ds(ds), .oe(oe), .sel(sel), .seg(seg), .blank(blank),
      .frame_valid(frame_valid), .frame_err(frame_err), .digits(digits)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "timeout");
   end

   function automatic logic [47:0] m_digits();
      logic [47:0] d;
      for (int i = 0; i < 6; i++) d[8*i +: 8] = m_dig[i];
      return d;
   endfunction

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_shift = '0;
      m_cnt   = 0;
      m_sel   = '0;
      m_seg   = '0;
      for (int i = 0; i < 6; i++) m_dig[i] = '0;
   endtask

   task automatic shift_bit(input logic b);
      @(negedge sys_clk) ds = b;
      repeat (2) @(negedge sys_clk);
      shcp = 1'b1;
      repeat (3) @(negedge sys_clk);
      shcp = 1'b0;
      repeat (2) @(negedge sys_clk);
      m_shift = {m_shift[12:0], b};
      if (m_cnt < 15) m_cnt++;
   endtask

   // Shift the low n bits of w, most significant first.
   task automatic shift_word(input logic [15:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
   endtask

   task automatic do_reset();
      @(negedge sys_clk) sys_rst = 1'b1;
      repeat (2) @(negedge sys_clk);
      check("rst_blank", 48'(blank), 48'(1));
      check("rst_sel", 48'(sel), 48'(0));
      check("rst_digits", digits, 48'(0));
      sys_rst = 1'b0;
      model_reset();
   endtask

   // Raise stcp (optionally together with shcp) and check the latched frame
   // appears exactly on the 4th rising clock edge.
   task automatic latch(input string tag, input logic with_shift, input logic b);
      logic [13:0] f;
      logic        e;
      f = m_shift;
      e = (m_cnt != 14) || ($countones(f[5:0]) != 1);
      @(negedge sys_clk) if (with_shift) ds = b;
      repeat (2) @(negedge sys_clk);
      shcp = with_shift;
      stcp = 1'b1;
      m_sel = f[5:0];
      m_seg = f[13:6];
      if (!e)
         for (int i = 0; i < 6; i++) if (f[i]) m_dig[i] = f[13:6];
      if (with_shift) begin
         m_shift = {m_shift[12:0], b};
         m_cnt   = 1;
      end else begin
         m_cnt = 0;
      end
      for (int k = 1; k <= 4; k++) begin
         @(posedge sys_clk);
         #1;
         if (k < 4) begin
            check({tag, "_early_valid"}, 48'(frame_valid), 48'(0));
         end else begin
            check({tag, "_valid"}, 48'(frame_valid), 48'(1));
            check({tag, "_err"}, 48'(frame_err), 48'(e));
            check({tag, "_sel"}, 48'(sel), 48'(m_sel));
            check({tag, "_seg"}, 48'(seg), 48'(m_seg));
            check({tag, "_digits"}, digits, m_digits());
            check({tag, "_blank"}, 48'(blank), 48'(m_oe));
         end
      end
      @(posedge sys_clk);
      #1;
      check({tag, "_pulse_end"}, 48'({frame_valid, frame_err}), 48'(0));
      @(negedge sys_clk);
      shcp = 1'b0;
      stcp = 1'b0;
      repeat (2) @(negedge sys_clk);
   endtask

   initial begin
      int          seen;
      int          n;
      logic [5:0]  rs;
      logic [7:0]  rg;
      logic [15:0] w;

      sys_rst = 1'b1;
      shcp = 1'b0; stcp = 1'b0; ds = 1'b0; oe = 1'b0;
      model_reset();
      m_oe = 1'b0;
      repeat (3) @(negedge sys_clk);
      check("reset_sel", 48'(sel), 48'(0));
      check("reset_seg", 48'(seg), 48'(0));
      check("reset_digits", digits, 48'(0));
      check("reset_flags", 48'({frame_valid, frame_err}), 48'(0));
      check("reset_blank", 48'(blank), 48'(1));
      sys_rst = 1'b0;
      repeat (4) @(negedge sys_clk);
      check("blank_follows_oe", 48'(blank), 48'(0));

      // Single good frame.
      shift_word(16'b11000000_000001, 14);
      latch("first", 1'b0, 1'b0);

      // Six good frames fill every digit slot.
      for (int i = 0; i < 6; i++) begin
         shift_word({2'b00, 8'(i + 1), 6'(1 << i)}, 14);
         latch($sformatf("six%0d", i), 1'b0, 1'b0);
      end
      check("six_digits_const", digits, 48'h060504030201);

      // Short frame, then a two-hot select.
      shift_word(16'($urandom), 13);
      latch("short13", 1'b0, 1'b0);
      shift_word({2'b00, 8'hAA, 6'b000011}, 14);
      latch("twohot", 1'b0, 1'b0);
      check("twohot_digits_const", digits, 48'h060504030201);

      // Back-to-back latches with no shifting.
      latch("empty_a", 1'b0, 1'b0);
      latch("empty_b", 1'b0, 1'b0);

      // Simultaneous shcp/stcp: 15th bit goes into the next frame.
      shift_word({2'b00, 8'h5A, 6'b000100}, 14);
      latch("simul", 1'b1, 1'b1);
      shift_word({2'b00, 8'h96, 6'b001000}, 13);
      latch("after_simul", 1'b0, 1'b0);

      // Reset mid-frame with oe high, then a clean frame and a short one.
      @(negedge sys_clk) oe = 1'b1;
      m_oe = 1'b1;
      repeat (4) @(negedge sys_clk);
      shift_word(16'h007F, 7);
      do_reset();
      repeat (3) @(negedge sys_clk);
      check("post_rst_blank", 48'(blank), 48'(1));
      shift_word({2'b00, 8'h3C, 6'b010000}, 14);
      latch("rst_clean", 1'b0, 1'b0);
      shift_word(16'h0015, 5);
      latch("rst_short", 1'b0, 1'b0);

      // Random frames: random length, mostly one-hot selects, random oe.
      for (int it = 0; it < 24; it++) begin
         oe   = 1'($urandom);
         m_oe = oe;
         n  = $urandom_range(12, 15);
         rg = 8'($urandom);
         rs = ($urandom_range(0, 3) != 0) ? 6'(1 << $urandom_range(0, 5)) : 6'($urandom);
         w  = {2'($urandom), rg, rs};
         shift_word(w, n);
         latch($sformatf("rnd%0d", it), 1'b0, 1'b0);
      end

      // stcp held high through reset release gives exactly one rise.
      @(negedge sys_clk) stcp = 1'b1;
      repeat (8) @(negedge sys_clk);
      sys_rst = 1'b1;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      model_reset();
      seen = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge sys_clk);
         #1;
         if (frame_valid) begin
            seen = k;
            break;
         end
      end
      check("held_stcp_latency", 48'(seen), 48'(4));
      check("held_stcp_err", 48'(frame_err), 48'(1));
      repeat (6) @(posedge sys_clk);
      #1;
      check("held_stcp_single", 48'(frame_valid), 48'(0));
      @(negedge sys_clk) stcp = 1'b0;
      repeat (3) @(negedge sys_clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
